sum_loop_ctrl: RTL and testbench
================================

# sum_loop_ctrl

Sequencer and two-way arbiter for the shared bounded-accumulation datapath, an `i`/`sn` counter pair. Each requester submits a job of the form (limit, thresh). The block grants jobs round-robin, initialises the datapath and steps it one iteration per cycle. On completion it returns the final `sn` to the job's owner through a valid/ready result port. It sits between the requesting engines and the counter datapath, which it owns exclusively.

## Interface
Parameters:
- `W`, default 11: datapath width of `i`, `sn`, limit and thresh.

Ports:
- `clk`, in, 1: clock.
- `rst`, in, 1: reset, synchronous, active-high.
- `req_valid`, in, 2: per-requester job request. Must be held, with operands stable, until accepted.
- `req_limit`, in, 2*W: per-requester loop bound; slice k is requester k.
- `req_thresh`, in, 2*W: per-requester accumulate threshold; slice k is requester k.
- `req_ready`, out, 2: one-hot accept, combinational. A job transfers when `req_valid[k] & req_ready[k]`.
- `busy`, out, 1: high in RUN or DONE.
- `i`, out, W: loop index register.
- `sn`, out, W: accumulator register.
- `done_valid`, out, 1: result available.
- `done_id`, out, 1: owner of the result.
- `done_sn`, out, W: final accumulator value, equal to `sn`.
- `done_ready`, in, 1: consumer accepts the result.

## Operation
- FSM states are IDLE, RUN and DONE. Reset enters IDLE.
- IDLE:
  - If any `req_valid` bit is set, the arbiter grants exactly one requester and drives its `req_ready` bit.
  - On the grant edge: latch limit, thresh and id; load `i`=1 and `sn`=0; go to RUN.
  - `req_ready` is 0 in every state other than IDLE, and while `rst` is high.
- Arbitration is round-robin:
  - The pointer names the preferred requester. It resets to 0.
  - After each grant, the pointer moves to the other requester.
  - If only one requester is valid, it wins regardless of the pointer.
- RUN, each cycle:
  - If `i` <= limit: `i` <= `i`+1, and if `i` <= thresh, `sn` <= `sn`+1.
  - Otherwise (`i` = limit+1): hold both registers and go to DONE.
- DONE:
  - `done_valid`=1; `done_id` and `done_sn` are stable.
  - On `done_ready`, return to IDLE.
  - `i` and `sn` hold their values in DONE and IDLE.
- Result: `done_sn` = min(limit, thresh).
- Invariant throughout RUN/DONE: `i` <= thresh or `sn` = min(thresh, limit).
- Width rules:
  - Comparisons are unsigned.
  - A limit of all-ones is clamped to 2^W−2 at latch time, so `i` never wraps.
  - thresh is used unclamped.
  - `sn` cannot overflow because `sn` < `i`.
- Boundary cases:
  - Limit 0: RUN lasts one cycle and the result is `sn`=0.
  - thresh 0: the result is 0.
  - thresh >= limit: the result is limit.
- Reset mid-RUN or mid-DONE: the job is aborted with no result; `i`=1, `sn`=0, `done_valid`=0 and the pointer returns to 0.

## Timing
- Reset values: `i`=1, `sn`=0, `busy`=0, `done_valid`=0, `done_id`=0, `done_sn`=0 (it mirrors `sn`), `req_ready`=0.
- Job accepted in cycle T:
  - Cycles T+1 through T+limit+1 are RUN.
  - `done_valid` is first high in cycle T+limit+2.
- Result latency is limit+2 cycles from accept.
- `done_valid`, once high, stays high until the cycle `done_ready` is sampled high.
- After the DONE→IDLE edge, the next grant is possible in the first IDLE cycle. Minimum job-to-job spacing is limit+3 cycles.
- A request asserted while busy waits; requests are never dropped.

## Structure
- Package `sum_loop_pkg` holds:
  - the state enum typedef (IDLE/RUN/DONE);
  - the requester-id width constant (1);
  - the default width `W`=11;
  - a helper function clamping limit to 2^W−2.
- Sub-module `rr_arb2`: a two-requester round-robin arbiter.
  - Inputs: `clk`, `rst`, `req[1:0]`, `advance`.
  - Output: `gnt[1:0]`.
  - The pointer updates on `advance`, which is driven by the accept event.
- The `i`/`sn` datapath and FSM live in `sum_loop_ctrl`.

## Test plan
- Requester 0 alone, limit=250, thresh=150, `done_ready`=1:
  - accept at T; `done_valid` at T+252 with `done_sn`=150, `done_id`=0;
  - `i`=251 at done;
  - invariant holds every cycle.
- Both valid from reset with identical jobs (limit=5, thresh=3):
  - grant order is 0, 1, 0, 1;
  - each result is 3;
  - `req_ready` is never high while busy.
- Edge jobs:
  - limit=0 → result 0 at T+2;
  - thresh=0 → result 0;
  - thresh=2047, limit=10 → result 10;
  - limit=2047 → clamped to 2046, result = min(2046, thresh), `i` never wraps.
- Back-pressure: hold `done_ready`=0 for 20 cycles.
  - `done_valid`, `done_sn` and `i` stay stable.
  - No new grant while stalled; requester 1 is granted in the cycle after release.
- Reset mid-RUN, asserted at `i`=100:
  - next cycle shows `i`=1, `sn`=0, `busy`=0, `done_valid`=0;
  - the pending requester 1 wins first after reset only if requester 0 is idle, otherwise requester 0 wins (pointer back at 0).

Source files
------------

// File: rtl/sum_loop_pkg.sv
// Shared types and constants for the sum_loop_ctrl sequencer.
package sum_loop_pkg;

    localparam int unsigned ID_W  = 1;
    localparam int unsigned DEF_W = 11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // An all-ones limit would let i wrap past limit+1, so pull it back by one.
    function automatic logic [31:0] clamp_limit(input logic [31:0] lim, input int unsigned w);
        logic [31:0] ones;
        ones = (32'(1) << w) - 32'(1);
        return (lim == ones) ? (ones - 32'(1)) : lim;
    endfunction

endpackage

// File: rtl/sum_loop_ctrl_if.sv
// Request/result bundle between requesting engines and sum_loop_ctrl.
interface sum_loop_ctrl_if
    import sum_loop_pkg::*;
#(
    parameter int unsigned W = DEF_W
) ();

    logic [1:0]      req_valid;
    logic [2*W-1:0]  req_limit;
    logic [2*W-1:0]  req_thresh;
    logic [1:0]      req_ready;
    logic            busy;
    logic [W-1:0]    i;
    logic [W-1:0]    sn;
    logic            done_valid;
    logic [ID_W-1:0] done_id;
    logic [W-1:0]    done_sn;
    logic            done_ready;

    modport slave (
        input  req_valid, req_limit, req_thresh, done_ready,
        output req_ready, busy, i, sn, done_valid, done_id, done_sn
    );

    modport master (
        output req_valid, req_limit, req_thresh, done_ready,
        input  req_ready, busy, i, sn, done_valid, done_id, done_sn
    );

endinterface

// File: rtl/sum_loop_ctrl_rr_arb2.sv
// Two-requester round-robin arbiter; pointer flips away from each winner on advance.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);

    logic ptr_q;

    // A lone requester wins outright; the pointer only settles contention.
    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = ptr_q ? 2'b10 : 2'b01;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= 1'b0;
        end else if (advance) begin
            ptr_q <= gnt[0];
        end
    end

endmodule

// File: rtl/sum_loop_ctrl.sv
// Arbitrates two job requesters onto the shared i/sn bounded-accumulation datapath.
module sum_loop_ctrl
    import sum_loop_pkg::*;
#(
    parameter int unsigned W = DEF_W
) (
    input  logic            clk,
    input  logic            rst,
    sum_loop_ctrl_if.slave  bus
);

    state_t          state_q, state_n;
    logic [W-1:0]    i_q, sn_q, lim_q, thr_q;
    logic [ID_W-1:0] id_q;

    logic [1:0]      gnt;
    logic            accept_c;
    logic [W-1:0]    sel_lim_c, sel_thr_c;
    logic [ID_W-1:0] sel_id_c;

    rr_arb2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (bus.req_valid),
        .advance (accept_c),
        .gnt     (gnt)
    );

    // Operand mux for the granted requester.
    always_comb begin
        sel_id_c  = ID_W'(gnt[1]);
        sel_lim_c = gnt[1] ? bus.req_limit[2*W-1:W]  : bus.req_limit[W-1:0];
        sel_thr_c = gnt[1] ? bus.req_thresh[2*W-1:W] : bus.req_thresh[W-1:0];
    end

    assign accept_c      = (state_q == IDLE) && !rst && (gnt != 2'b00);
    assign bus.req_ready = ((state_q == IDLE) && !rst) ? gnt : 2'b00;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_n;
        end
    end

    always_comb begin
        state_n = state_q;
        case (state_q)
            IDLE:    if (accept_c)        state_n = RUN;
            RUN:     if (i_q > lim_q)     state_n = DONE;
            DONE:    if (bus.done_ready)  state_n = IDLE;
            default:                      state_n = IDLE;
        endcase
    end

    // i counts 1..limit+1; sn counts how many of those steps were within thresh.
    always_ff @(posedge clk) begin
        if (rst) begin
            i_q   <= W'(1);
            sn_q  <= '0;
            lim_q <= '0;
            thr_q <= '0;
            id_q  <= '0;
        end else if (accept_c) begin
            i_q   <= W'(1);
            sn_q  <= '0;
            lim_q <= W'(clamp_limit(32'(sel_lim_c), W));
            thr_q <= sel_thr_c;
            id_q  <= sel_id_c;
        end else if ((state_q == RUN) && (i_q <= lim_q)) begin
            i_q <= i_q + W'(1);
            if (i_q <= thr_q) begin
                sn_q <= sn_q + W'(1);
            end
        end
    end

    assign bus.busy       = (state_q != IDLE);
    assign bus.done_valid = (state_q == DONE);
    assign bus.done_id    = id_q;
    assign bus.done_sn    = sn_q;
    assign bus.i          = i_q;
    assign bus.sn         = sn_q;

endmodule

// File: tb/tb_sum_loop_ctrl.sv
// Self-checking bench for sum_loop_ctrl: job-level reference model plus directed and random jobs.
module tb_sum_loop_ctrl;
    import sum_loop_pkg::*;

    localparam int unsigned W    = 11;
    localparam int          ONES = (1 << W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sum_loop_ctrl_if #(.W(W)) bus ();
    sum_loop_ctrl #(.W(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    int pass_cnt  = 0;
    int total_cnt = 0;
    int cyc       = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic int mn(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    // Job-level model: a job accepted at T shows i=k, sn=min(k-1,thr) in cycle T+k, then DONE.
    bit   m_act = 0;
    bit   m_ptr = 0;
    int   m_k, m_lim, m_thr, m_owner;
    int   m_i = 1, m_sn = 0, m_did = 0;
    int   exp_id_q[$], exp_sn_q[$];

    logic [1:0] acc_seen = 2'b00;
    int   acc_cycle = 0, acc_id = 0, hs_cnt = 0, hs_cycle = 0;
    int   grants_q[$], res_sn_q[$];
    bit   dv_prev = 0;
    int   rise_cycle = 0, rise_sn = 0, rise_i = 0, rise_id = 0;

    always @(negedge clk) begin
        int         e_busy, e_dv, e_i, e_sn, raw;
        logic [1:0] e_rr;
        cyc++;
        acc_seen = bus.req_valid & bus.req_ready;
        if (rst) begin
            chk("req_ready_in_reset", 32'(bus.req_ready), 0);
            m_act = 0; m_ptr = 0; m_i = 1; m_sn = 0; m_did = 0;
            exp_id_q.delete(); exp_sn_q.delete();
            dv_prev = 0; acc_seen = 2'b00;
        end else begin
            e_rr = 2'b00;
            if (!m_act) begin
                e_busy = 0; e_dv = 0; e_i = m_i; e_sn = m_sn;
                if (bus.req_valid == 2'b11) e_rr = m_ptr ? 2'b10 : 2'b01;
                else                        e_rr = bus.req_valid;
            end else if (m_k <= m_lim + 1) begin
                e_busy = 1; e_dv = 0; e_i = m_k; e_sn = mn(m_k - 1, m_thr);
            end else begin
                e_busy = 1; e_dv = 1; e_i = m_lim + 1; e_sn = mn(m_lim, m_thr);
            end
            chk("req_ready",  32'(bus.req_ready),  32'(e_rr));
            chk("busy",       32'(bus.busy),       e_busy);
            chk("done_valid", 32'(bus.done_valid), e_dv);
            chk("i",          32'(bus.i),          e_i);
            chk("sn",         32'(bus.sn),         e_sn);
            chk("done_sn",    32'(bus.done_sn),    e_sn);
            chk("done_id",    32'(bus.done_id),    m_did);

            if (bus.done_valid && !dv_prev) begin
                rise_cycle = cyc; rise_sn = int'(bus.done_sn);
                rise_i = int'(bus.i); rise_id = int'(bus.done_id);
            end
            dv_prev = bus.done_valid;
            if (acc_seen != 2'b00) begin
                acc_cycle = cyc; acc_id = int'(acc_seen[1]);
                grants_q.push_back(acc_id);
            end
            if (bus.done_valid && bus.done_ready) begin
                hs_cnt++; hs_cycle = cyc;
                res_sn_q.push_back(int'(bus.done_sn));
                if (exp_sn_q.size() > 0) begin
                    chk("result_id", 32'(bus.done_id), exp_id_q.pop_front());
                    chk("result_sn", 32'(bus.done_sn), exp_sn_q.pop_front());
                end else begin
                    chk("unexpected_result", 32'(bus.done_valid), 0);
                end
            end

            if (!m_act) begin
                if (e_rr != 2'b00) begin
                    m_owner = int'(e_rr[1]);
                    raw   = m_owner ? int'(bus.req_limit[2*W-1:W]) : int'(bus.req_limit[W-1:0]);
                    m_lim = (raw == ONES) ? ONES - 1 : raw;
                    m_thr = m_owner ? int'(bus.req_thresh[2*W-1:W]) : int'(bus.req_thresh[W-1:0]);
                    m_act = 1; m_k = 1; m_ptr = ~e_rr[1]; m_did = m_owner;
                    exp_id_q.push_back(m_owner);
                    exp_sn_q.push_back(mn(m_lim, m_thr));
                end
            end else if (m_k <= m_lim + 1) begin
                m_k++;
            end else if (bus.done_ready) begin
                m_act = 0; m_i = m_lim + 1; m_sn = mn(m_lim, m_thr);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) if (acc_seen[k]) bus.req_valid[k] = 1'b0;
    endtask

    task automatic submit(input int k, input int lim, input int thr);
        bus.req_limit[k*W +: W]  = W'(lim);
        bus.req_thresh[k*W +: W] = W'(thr);
        bus.req_valid[k]         = 1'b1;
    endtask

    task automatic wait_acc(input int k);
        for (int n = 0; n < 6000 && bus.req_valid[k]; n++) step();
        chk("accept_wait", 32'(bus.req_valid[k]), 0);
    endtask

    task automatic wait_hs(input int target);
        for (int n = 0; n < 6000 && hs_cnt < target; n++) step();
        chk("result_wait", 32'(hs_cnt >= target), 1);
    endtask

    initial begin
        int base, gq, n;
        int edge_tab [5][3] = '{'{0, 5, 0}, '{7, 0, 0}, '{10, 2047, 10},
                                '{2047, 2047, 2046}, '{2047, 300, 300}};
        bus.req_valid = '0; bus.req_limit = '0; bus.req_thresh = '0; bus.done_ready = 1'b0;
        repeat (3) step();
        rst = 1'b0;
        chk("rst_i", 32'(bus.i), 1);
        chk("rst_sn", 32'(bus.sn), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_done_valid", 32'(bus.done_valid), 0);
        chk("rst_done_id", 32'(bus.done_id), 0);
        chk("rst_done_sn", 32'(bus.done_sn), 0);
        chk("rst_req_ready", 32'(bus.req_ready), 0);

        // Single long job from requester 0.
        bus.done_ready = 1'b1;
        base = hs_cnt;
        submit(0, 250, 150);
        wait_acc(0);
        wait_hs(base + 1);
        chk("t1_latency", rise_cycle - acc_cycle, 252);
        chk("t1_sn", rise_sn, 150);
        chk("t1_id", rise_id, 0);
        chk("t1_i", rise_i, 251);

        // Both requesters contending from reset.
        rst = 1'b1; repeat (2) step(); rst = 1'b0;
        grants_q.delete();
        base = hs_cnt;
        submit(0, 5, 3); submit(1, 5, 3);
        for (int g = 0; g < 4; g++) begin
            for (n = 0; n < 200 && grants_q.size() <= g; n++) step();
            if (g < 2 && grants_q.size() > g) submit(grants_q[g], 5, 3);
        end
        wait_hs(base + 4);
        chk("t2_grant_count", grants_q.size(), 4);
        if (grants_q.size() >= 4)
            for (int g = 0; g < 4; g++) chk("t2_grant_order", grants_q[g], g % 2);
        if (res_sn_q.size() >= 4)
            for (int g = 1; g <= 4; g++) chk("t2_result", res_sn_q[res_sn_q.size() - g], 3);

        // Boundary jobs.
        for (int e = 0; e < 5; e++) begin
            base = hs_cnt;
            submit(0, edge_tab[e][0], edge_tab[e][1]);
            wait_acc(0);
            wait_hs(base + 1);
            chk("edge_result", rise_sn, edge_tab[e][2]);
            chk("edge_latency", rise_cycle - acc_cycle,
                ((edge_tab[e][0] == ONES) ? ONES - 1 : edge_tab[e][0]) + 2);
            chk("edge_i_at_done", rise_i,
                ((edge_tab[e][0] == ONES) ? ONES - 1 : edge_tab[e][0]) + 1);
        end

        // Back-pressure on the result port while requester 1 waits.
        bus.done_ready = 1'b0;
        base = hs_cnt;
        submit(0, 8, 5);
        wait_acc(0);
        for (n = 0; n < 100 && !bus.done_valid; n++) step();
        submit(1, 3, 3);
        gq = grants_q.size();
        repeat (20) step();
        chk("bp_done_valid", 32'(bus.done_valid), 1);
        chk("bp_done_sn", 32'(bus.done_sn), 5);
        chk("bp_i", 32'(bus.i), 9);
        chk("bp_no_grant", grants_q.size(), gq);
        bus.done_ready = 1'b1;
        step();
        wait_acc(1);
        chk("bp_regrant_delay", acc_cycle - hs_cycle, 1);
        chk("bp_regrant_id", acc_id, 1);
        wait_hs(base + 2);

        // Reset mid-RUN with both requesters wanting service: pointer is back at 0.
        submit(0, 300, 200);
        wait_acc(0);
        submit(1, 4, 4);
        for (n = 0; n < 400 && bus.i != W'(100); n++) step();
        rst = 1'b1;
        step();
        chk("mr_i", 32'(bus.i), 1);
        chk("mr_sn", 32'(bus.sn), 0);
        chk("mr_busy", 32'(bus.busy), 0);
        chk("mr_done_valid", 32'(bus.done_valid), 0);
        submit(0, 4, 2);
        gq = grants_q.size();
        rst = 1'b0;
        wait_acc(0);
        chk("mr_first_grant", (grants_q.size() > gq) ? grants_q[gq] : 9, 0);
        wait_acc(1);

        // Reset mid-RUN with only requester 1 pending: it wins.
        for (n = 0; n < 100 && bus.busy; n++) step();
        submit(0, 50, 50);
        wait_acc(0);
        submit(1, 2, 2);
        for (n = 0; n < 100 && bus.i != W'(20); n++) step();
        rst = 1'b1;
        step();
        gq = grants_q.size();
        rst = 1'b0;
        wait_acc(1);
        chk("mr2_first_grant", (grants_q.size() > gq) ? grants_q[gq] : 9, 1);

        // Random traffic with random result back-pressure.
        for (int c = 0; c < 2500; c++) begin
            step();
            for (int k = 0; k < 2; k++)
                if (!bus.req_valid[k] && $urandom_range(0, 3) == 0)
                    submit(k, $urandom_range(0, 30), $urandom_range(0, 35));
            bus.done_ready = ($urandom_range(0, 2) != 0);
        end
        bus.done_ready = 1'b1;
        wait_acc(0);
        wait_acc(1);
        for (n = 0; n < 200 && bus.busy; n++) step();
        chk("drain_idle", 32'(bus.busy), 0);
        chk("drain_scoreboard", exp_sn_q.size(), 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish, %0d of %0d checks passed", pass_cnt, total_cnt);
        $fatal(1, "watchdog");
    end

endmodule
